rca_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer that performs a WIDTH-bit add by time-sharing one external CHUNK-bit ripple-carry adder.

---
 rtl/rca_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Sequencer that computes a WIDTH-bit add by stepping one shared CHUNK-bit ripple-carry adder, LSB slice first.
// Optional signed-overflow output out_ovf is enabled by defining RCA_SEQ_OVF_EN.
module rca_seq_ctrl #(
  parameter int WIDTH  = 128,
  parameter int CHUNK  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_sum,
  input  logic             add_cout,
`ifdef RCA_SEQ_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [KW-1:0]                k;
  logic [CW-1:0]                cnt;
  logic [NCHUNK-1:0][CHUNK-1:0] x_r, y_r, sum_r;
  logic                         c_r;
  logic                         accept, slice_done, last_slice;

  assign in_ready   = rst_n & (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign slice_done = (state == RUN) && (cnt == CW'(SETTLE - 1));
  assign last_slice = (k == KW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (slice_done && last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each slice result is captured on the last settle cycle; its carry feeds the next slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k     <= '0;
      cnt   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      c_r   <= 1'b0;
      sum_r <= '0;
    end else if (accept) begin
      x_r <= in_x;
      y_r <= in_y;
      c_r <= in_cin;
      k   <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (slice_done) begin
        sum_r[k] <= add_sum;
        c_r      <= add_cout;
        cnt      <= '0;
        if (!last_slice) k <= k + KW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = x_r[k];
      add_b   = y_r[k];
      add_cin = c_r;
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_sum   = sum_r;
  assign out_cout  = c_r;

`ifdef RCA_SEQ_OVF_EN
  logic ovf_r;

  // The top slice's sum arrives on the same edge it is stored, so overflow is taken from add_sum.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      ovf_r <= 1'b0;
    end else if (slice_done && last_slice) begin
      ovf_r <= (x_r[NCHUNK-1][CHUNK-1] == y_r[NCHUNK-1][CHUNK-1]) &&
               (add_sum[CHUNK-1] != x_r[NCHUNK-1][CHUNK-1]);
    end
  end

  assign out_ovf = ovf_r & (state == DONE);
`endif

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Randomised self-checking bench for rca_seq_ctrl against a plain-arithmetic reference model.
// Builds with or without RCA_SEQ_OVF_EN; the overflow checks follow the macro.
module tb_rca_seq_ctrl;

   localparam int WIDTH  = 128;
   localparam int CHUNK  = 32;
   localparam int SETTLE = 1;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic [CHUNK-1:0] add_a;
   logic [CHUNK-1:0] add_b;
   logic             add_cin;
   logic [CHUNK-1:0] add_sum;
   logic             add_cout;
   logic             busy;
`ifdef RCA_SEQ_OVF_EN
   logic             out_ovf;
`endif

   int total = 0;
   int bad   = 0;

   rca_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SETTLE(SETTLE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_x(in_x),
      .in_y(in_y),
      .in_cin(in_cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum),
      .out_cout(out_cout),
      .add_a(add_a),
      .add_b(add_b),
      .add_cin(add_cin),
      .add_sum(add_sum),
      .add_cout(add_cout),
`ifdef RCA_SEQ_OVF_EN
      .out_ovf(out_ovf),
`endif
      .busy(busy)
   );

   // The external shared adder: a plain combinational CHUNK-bit add.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{CHUNK{1'b0}}, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench is routed through here.
   task automatic checkOutput(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Carry that must enter slice i: the carry out of the low i*CHUNK bits of x+y+cin.
   function automatic logic [NCHUNK-1:0] expCarryTrace(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                       input logic cin);
      logic [NCHUNK-1:0] t;
      logic [WIDTH:0]    m;
      logic [WIDTH:0]    s;
      t = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         m    = ({{WIDTH{1'b0}}, 1'b1} << (CHUNK * i)) - 1'b1;
         s    = ({1'b0, x} & m) + ({1'b0, y} & m) + {{WIDTH{1'b0}}, cin};
         t[i] = s[CHUNK * i];
      end
      return t;
   endfunction

   // Present one operand pair, wait for the result, and record what the shared adder was driven with.
   task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin,
                                output int lat, output logic [NCHUNK-1:0] trace, output logic slices_ok);
      int n;
      int slot;
      in_x     = x;
      in_y     = y;
      in_cin   = cin;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         cycle();
         n++;
      end
      if (!in_ready) checkOutput("accept_timeout", '0, {{WIDTH{1'b0}}, 1'b1});
      cycle();
      in_valid  = 1'b0;
      lat       = 0;
      trace     = '0;
      slices_ok = 1'b1;
      while (!out_valid && lat < 64) begin
         slot = lat / SETTLE;
         if (busy && slot < NCHUNK) begin
            trace[slot] = add_cin;
            if (add_a !== CHUNK'(x >> (CHUNK * slot))) slices_ok = 1'b0;
            if (add_b !== CHUNK'(y >> (CHUNK * slot))) slices_ok = 1'b0;
         end else begin
            slices_ok = 1'b0;
         end
         cycle();
         lat++;
      end
   endtask

   // Full transaction: check result, latency, slice traffic, stall stability and the output handshake.
   task automatic runCheck(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin, input int stall);
      int                lat;
      logic [NCHUNK-1:0] trace;
      logic              slices_ok;
      logic [WIDTH:0]    ref_full;
      ref_full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      applyStimulus(x, y, cin, lat, trace, slices_ok);
      checkOutput("latency", (WIDTH+1)'(lat), (WIDTH+1)'(NCHUNK * SETTLE));
      checkOutput("carry_trace", (WIDTH+1)'(trace), (WIDTH+1)'(expCarryTrace(x, y, cin)));
      checkOutput("slice_operands", (WIDTH+1)'(slices_ok), (WIDTH+1)'(1));
      checkOutput("sum", {1'b0, out_sum}, {1'b0, ref_full[WIDTH-1:0]});
      checkOutput("cout", (WIDTH+1)'(out_cout), (WIDTH+1)'(ref_full[WIDTH]));
`ifdef RCA_SEQ_OVF_EN
      checkOutput("ovf", (WIDTH+1)'(out_ovf),
                  (WIDTH+1)'((x[WIDTH-1] == y[WIDTH-1]) && (ref_full[WIDTH-1] != x[WIDTH-1])));
`endif
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         cycle();
         checkOutput("stall_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
         checkOutput("stall_sum", {1'b0, out_sum}, {1'b0, ref_full[WIDTH-1:0]});
         checkOutput("stall_in_ready", (WIDTH+1)'(in_ready), '0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checkOutput("post_hs_valid", (WIDTH+1)'(out_valid), '0);
      checkOutput("post_hs_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
`ifdef RCA_SEQ_OVF_EN
      checkOutput("post_hs_ovf", (WIDTH+1)'(out_ovf), '0);
`endif
   endtask

   initial begin
      logic [WIDTH-1:0] rx, ry;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_cin    = 1'b0;
      cycle();
      cycle();
      checkOutput("rst_out_valid", (WIDTH+1)'(out_valid), '0);
      checkOutput("rst_busy", (WIDTH+1)'(busy), '0);
      checkOutput("rst_in_ready", (WIDTH+1)'(in_ready), '0);
      checkOutput("rst_sum", {out_cout, out_sum}, '0);
      checkOutput("rst_add", {add_cin, add_a, add_b}, '0);
      rst_n = 1'b1;
      cycle();
      checkOutput("idle_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));

      runCheck({WIDTH{1'b1}}, (WIDTH)'(1), 1'b0, 0);
      runCheck((WIDTH)'(64'h0000_FFFF_FFFF), (WIDTH)'(1), 1'b0, 0);
      runCheck((WIDTH)'(5), (WIDTH)'(7), 1'b1, 10);
      runCheck({1'b0, {(WIDTH-1){1'b1}}}, (WIDTH)'(1), 1'b0, 1);

      // Reset while the third slice is on the adder must discard the add entirely.
      in_x     = {4{32'hDEAD_BEEF}};
      in_y     = {4{32'h1234_5678}};
      in_cin   = 1'b1;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      checkOutput("mid_run_busy", (WIDTH+1)'(busy), (WIDTH+1)'(1));
      rst_n = 1'b0;
      cycle();
      checkOutput("mid_rst_valid", (WIDTH+1)'(out_valid), '0);
      checkOutput("mid_rst_busy", (WIDTH+1)'(busy), '0);
      checkOutput("mid_rst_add", {add_cin, add_a, add_b}, '0);
      checkOutput("mid_rst_in_ready", (WIDTH+1)'(in_ready), '0);
      rst_n = 1'b1;
      cycle();
      runCheck((WIDTH)'(3), (WIDTH)'(4), 1'b0, 0);

      for (int n = 0; n < 1000; n++) begin
         rx = {$urandom, $urandom, $urandom, $urandom};
         ry = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ry = ~rx ^ (WIDTH)'($urandom_range(0, 3));
         runCheck(rx, ry, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
